alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
Multi-cycle issue/writeback sequencer for the AVR core's arithmetic path. It decodes one latched 16-bit instruction word and reads operands from the register file. It drives the combinational ALU (mode/d/r/s/op1w), captures R, S and resw, and writes results back into the register file. It also owns SREG, and sits between the fetch/decode stage and the ALU and register file.

Parameters:
None.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
start  in  1  accept `opcode` when idle
opcode  in  16  AVR instruction word
busy  out  1  high when not IDLE
done  out  1  1-cycle pulse: instruction retired
err  out  1  1-cycle pulse, coincident with done: unsupported opcode
rf_addr_a  out  5  read address A, combinational regfile
rf_data_a  in  8  data at rf_addr_a
rf_addr_b  out  5  read address B
rf_data_b  in  8  data at rf_addr_b
rf_we  out  1  register write strobe
rf_waddr  out  5  write address
rf_wdata  out  8  write data
alu_mode  out  5  ALU mode code
alu_d  out  8  ALU dst operand
alu_r  out  8  ALU src operand / immediate
alu_s  out  8  SREG into ALU
alu_op1w  out  16  16-bit operand (ADIW/SBIW)
alu_R  in  8  ALU 8-bit result
alu_S  in  8  ALU new flags
alu_resw  in  16  ALU 16-bit result
sreg  out  8  current SREG {I,T,H,S,V,N,Z,C}

Behaviour:
- Reset (sync, priority over everything): state=IDLE; sreg=0x00; busy=done=err=rf_we=0; latched opcode=0; hi-byte latch=0. A reset during EXEC or WRHI drops that cycle's write and any pending high-byte write.
- States:
  - IDLE -> EXEC on start. Latch opcode.
  - EXEC -> IDLE for 8-bit ops and errors.
  - EXEC -> WRHI for ADIW, SBIW and MUL.
  - WRHI -> IDLE.
- start while busy: ignored, no effect.
- EXEC cycle:
  - Drive the ALU combinationally from rf_data_a/b and sreg. alu_s=sreg always.
  - Write R or resw[7:0] with rf_we=1. No write for CP/CPC/CPI.
  - sreg<=alu_S for every flag-affecting op; MOV, LDI and SWAP leave sreg unchanged.
  - Latch resw[15:8] into the hi-byte register.
  - 8-bit ops and errors pulse done in EXEC.
- WRHI cycle: rf_we=1, rf_waddr=dst+1 (MUL: r1), rf_wdata=latched hi byte, done=1. The hi byte is never re-read from the ALU because the low write may have changed its operands.
- Latency: start at cycle 0 -> done at cycle 1 for 8-bit ops; cycle 2 for 16-bit ops.
- Decode:
  - d/r fields: d=opcode[8:4], r={opcode[9],opcode[3:0]}, K={opcode[11:8],opcode[3:0]}.
  - Two-register ops (mode in parentheses):
    - CPC 000001 (1), SBC 000010 (2), ADD 000011 (3), CP 000101 (5).
    - SUB 000110 (6), ADC 000111 (7), AND 001000 (8), EOR 001001 (9).
    - OR 001010 (10), MOV 001011 (0).
    - Operands: a=Rd, b=Rr, alu_d=a, alu_r=b.
  - Immediate ops (opcode[15:12]), mode in parentheses:
    - CPI 0011 (5), SBCI 0100 (2), SUBI 0101 (6), ORI 0110 (10), ANDI 0111 (8), LDI 1110 (0).
    - Destination is 16+opcode[7:4]; alu_r=K.
  - Single-register ops, 1001010d_dddd_xxxx with xxxx:
    - COM 0000 (12), NEG 0001 (13), SWAP 0010 (14), INC 0011 (15).
    - ASR 0101 (16), LSR 0110 (17), ROR 0111 (18), DEC 1010 (19).
  - ADIW 10010110 (20) and SBIW 10010111 (21):
    - dst=24+2*opcode[5:4], a=dst, b=dst+1.
    - alu_op1w={b,a}; alu_r={2'b0,opcode[7:6],opcode[3:0]}.
  - MUL 100111 (23): a=Rd, b=Rr, dst=r0, hi -> r1.
  - Any other word: err and done in EXEC, no rf_we, sreg unchanged.
- Idle outputs: alu_mode=0 and all ALU operands 0. rf_addr_a/b, rf_waddr and rf_wdata hold 0 whenever rf_we=0.
- Address arithmetic is 5-bit; dst+1 never wraps for legal encodings.

Test Plan:
- sreg=0x00, r1=0x7F, r2=0x01, ADD r1,r2 (0x0C12) -> cycle 1: rf_we, r1<=0x80, sreg=0x2C, done=1, err=0.
- r24=0xFF, r25=0xFF, sreg=0x00, ADIW r24,1 (0x9601):
  - cycle 1: r24<=0x00, sreg=0x03.
  - cycle 2: r25<=0x00, done.
- sreg=0x00, r16=0xFF, r17=0xFF, MUL r16,r17 (0x9F01) -> cycle 1: r0<=0x01, sreg=0x01; cycle 2: r1<=0xFE, done.
- r3=r4=0x10, CP r3,r4 (0x1434) -> no rf_we, sreg=0x02, done in cycle 1.
- ADIW issued, start pulsed again in cycle 1 -> ignored.
- ADIW issued, reset asserted in WRHI cycle -> no r25 write, sreg=0x00, state IDLE next cycle.
- Opcode 0xFFFF -> cycle 1: done=1, err=1, rf_we=0, sreg unchanged.

Source files
------------

// File: rtl/alu_issue.sv
// Issue/writeback sequencer for the AVR arithmetic path: decodes a latched
// instruction, drives the external combinational ALU and writes results back.
module alu_issue (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] opcode,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [4:0]  rf_addr_a,
    input  logic [7:0]  rf_data_a,
    output logic [4:0]  rf_addr_b,
    input  logic [7:0]  rf_data_b,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic [4:0]  alu_mode,
    output logic [7:0]  alu_d,
    output logic [7:0]  alu_r,
    output logic [7:0]  alu_s,
    output logic [15:0] alu_op1w,
    input  logic [7:0]  alu_R,
    input  logic [7:0]  alu_S,
    input  logic [15:0] alu_resw,
    output logic [7:0]  sreg
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WRHI} state_t;

    state_t      state_q, state_d;
    logic [15:0] opcode_q;
    logic [7:0]  sreg_q;
    logic [7:0]  hi_q;

    logic        is_rr, is_imm, is_single, is_word, is_mul;
    logic [4:0]  dec_mode;
    logic        dec_valid, dec_flags, dec_write, dec_two;
    logic [4:0]  dec_a, dec_b, dec_dst, dec_hi;

    logic [5:0]  op6;
    logic [4:0]  d_fld, r_fld, w_dst;
    logic [7:0]  k_fld;

    assign op6   = opcode_q[15:10];
    assign d_fld = opcode_q[8:4];
    assign r_fld = {opcode_q[9], opcode_q[3:0]};
    assign k_fld = {opcode_q[11:8], opcode_q[3:0]};
    // Word ops address the pairs r24/r26/r28/r30: 24 + 2*n
    assign w_dst = {2'b11, opcode_q[5:4], 1'b0};

    always_comb begin
        is_rr     = 1'b0;
        is_imm    = 1'b0;
        is_single = 1'b0;
        is_word   = 1'b0;
        is_mul    = 1'b0;
        dec_mode  = 5'd0;

        case (op6)
            6'b000001: begin is_rr = 1'b1; dec_mode = 5'd1;  end
            6'b000010: begin is_rr = 1'b1; dec_mode = 5'd2;  end
            6'b000011: begin is_rr = 1'b1; dec_mode = 5'd3;  end
            6'b000101: begin is_rr = 1'b1; dec_mode = 5'd5;  end
            6'b000110: begin is_rr = 1'b1; dec_mode = 5'd6;  end
            6'b000111: begin is_rr = 1'b1; dec_mode = 5'd7;  end
            6'b001000: begin is_rr = 1'b1; dec_mode = 5'd8;  end
            6'b001001: begin is_rr = 1'b1; dec_mode = 5'd9;  end
            6'b001010: begin is_rr = 1'b1; dec_mode = 5'd10; end
            6'b001011: begin is_rr = 1'b1; dec_mode = 5'd0;  end
            6'b100111: begin is_mul = 1'b1; dec_mode = 5'd23; end
            default: ;
        endcase

        case (opcode_q[15:12])
            4'b0011: begin is_imm = 1'b1; dec_mode = 5'd5;  end
            4'b0100: begin is_imm = 1'b1; dec_mode = 5'd2;  end
            4'b0101: begin is_imm = 1'b1; dec_mode = 5'd6;  end
            4'b0110: begin is_imm = 1'b1; dec_mode = 5'd10; end
            4'b0111: begin is_imm = 1'b1; dec_mode = 5'd8;  end
            4'b1110: begin is_imm = 1'b1; dec_mode = 5'd0;  end
            default: ;
        endcase

        if (opcode_q[15:9] == 7'b1001010) begin
            case (opcode_q[3:0])
                4'b0000: begin is_single = 1'b1; dec_mode = 5'd12; end
                4'b0001: begin is_single = 1'b1; dec_mode = 5'd13; end
                4'b0010: begin is_single = 1'b1; dec_mode = 5'd14; end
                4'b0011: begin is_single = 1'b1; dec_mode = 5'd15; end
                4'b0101: begin is_single = 1'b1; dec_mode = 5'd16; end
                4'b0110: begin is_single = 1'b1; dec_mode = 5'd17; end
                4'b0111: begin is_single = 1'b1; dec_mode = 5'd18; end
                4'b1010: begin is_single = 1'b1; dec_mode = 5'd19; end
                default: ;
            endcase
        end

        if (opcode_q[15:8] == 8'h96) begin
            is_word  = 1'b1;
            dec_mode = 5'd20;
        end else if (opcode_q[15:8] == 8'h97) begin
            is_word  = 1'b1;
            dec_mode = 5'd21;
        end
    end

    always_comb begin
        dec_valid = is_rr | is_imm | is_single | is_word | is_mul;
        // MOV/LDI (mode 0) and SWAP (mode 14) leave the flags alone
        dec_flags = dec_valid && (dec_mode != 5'd0) && (dec_mode != 5'd14);
        // CP/CPI (mode 5) and CPC (mode 1) only compare
        dec_write = dec_valid && (dec_mode != 5'd5) && (dec_mode != 5'd1);
        dec_two   = is_word | is_mul;

        dec_a = 5'd0;
        if (is_imm)
            dec_a = {1'b1, opcode_q[7:4]};
        else if (is_word)
            dec_a = w_dst;
        else if (is_rr || is_single || is_mul)
            dec_a = d_fld;

        dec_b = 5'd0;
        if (is_rr || is_mul)
            dec_b = r_fld;
        else if (is_word)
            dec_b = {w_dst[4:1], 1'b1};

        dec_dst = is_mul ? 5'd0 : dec_a;
        dec_hi  = is_mul ? 5'd1 : dec_dst + 5'd1;
    end

    always_comb begin
        state_d   = state_q;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        err       = 1'b0;
        rf_addr_a = 5'd0;
        rf_addr_b = 5'd0;
        rf_we     = 1'b0;
        rf_waddr  = 5'd0;
        rf_wdata  = 8'd0;
        alu_mode  = 5'd0;
        alu_d     = 8'd0;
        alu_r     = 8'd0;
        alu_s     = 8'd0;
        alu_op1w  = 16'd0;

        case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = (dec_valid && dec_two) ? S_WRHI : S_IDLE;
                alu_s   = sreg_q;
                done    = !(dec_valid && dec_two);
                err     = !dec_valid;
                if (dec_valid) begin
                    rf_addr_a = dec_a;
                    rf_addr_b = dec_b;
                    alu_mode  = dec_mode;
                    alu_d     = rf_data_a;
                    if (is_rr || is_mul)
                        alu_r = rf_data_b;
                    else if (is_imm)
                        alu_r = k_fld;
                    else if (is_word)
                        alu_r = {2'b00, opcode_q[7:6], opcode_q[3:0]};
                    if (is_word)
                        alu_op1w = {rf_data_b, rf_data_a};
                    if (dec_write) begin
                        rf_we    = 1'b1;
                        rf_waddr = dec_dst;
                        rf_wdata = dec_two ? alu_resw[7:0] : alu_R;
                    end
                end
            end
            S_WRHI: begin
                state_d  = S_IDLE;
                rf_we    = 1'b1;
                rf_waddr = dec_hi;
                rf_wdata = hi_q;
                done     = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Reset kills the in-flight write and handshake in the same cycle
        if (reset) begin
            busy     = 1'b0;
            done     = 1'b0;
            err      = 1'b0;
            rf_we    = 1'b0;
            rf_waddr = 5'd0;
            rf_wdata = 8'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            opcode_q <= 16'd0;
            sreg_q   <= 8'd0;
            hi_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start)
                opcode_q <= opcode;
            if (state_q == S_EXEC) begin
                if (dec_flags)
                    sreg_q <= alu_S;
                // High byte is captured now: the low write may alter the ALU inputs
                hi_q <= alu_resw[15:8];
            end
        end
    end

    assign sreg = sreg_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: stubbed register file and ALU responses,
// table-driven instruction vectors plus start-while-busy and reset sequences.
module tb_alu_issue;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] opcode;
    logic        busy, done, err;
    logic [4:0]  rf_addr_a, rf_addr_b, rf_waddr;
    logic [7:0]  rf_data_a, rf_data_b, rf_wdata;
    logic        rf_we;
    logic [4:0]  alu_mode;
    logic [7:0]  alu_d, alu_r, alu_s;
    logic [15:0] alu_op1w;
    logic [7:0]  alu_R, alu_S;
    logic [15:0] alu_resw;
    logic [7:0]  sreg;

    logic [7:0]  rf [32];
    int          checks;
    int          errors;
    logic [7:0]  exp_sreg;

    assign rf_data_a = rf[rf_addr_a];
    assign rf_data_b = rf[rf_addr_b];

    alu_issue dut (
        .clock(clock), .reset(reset), .start(start), .opcode(opcode),
        .busy(busy), .done(done), .err(err),
        .rf_addr_a(rf_addr_a), .rf_data_a(rf_data_a),
        .rf_addr_b(rf_addr_b), .rf_data_b(rf_data_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_mode(alu_mode), .alu_d(alu_d), .alu_r(alu_r), .alu_s(alu_s),
        .alu_op1w(alu_op1w), .alu_R(alu_R), .alu_S(alu_S), .alu_resw(alu_resw),
        .sreg(sreg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] op;
        logic [4:0]  ra, rb;      // expected read addresses
        logic [7:0]  va, vb;      // register contents at those addresses
        logic [4:0]  mode;
        logic [7:0]  ex_d, ex_r;  // expected alu_d / alu_r
        logic [15:0] ex_w;        // expected alu_op1w
        logic [7:0]  in_r, in_s;  // stubbed ALU R and S
        logic [15:0] in_w;        // stubbed ALU resw
        logic        we;
        logic [4:0]  wa;
        logic [7:0]  wd;
        logic        upd, two, er;
        logic [4:0]  ha;
        logic [7:0]  hd;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        rf[v.ra] = v.va;
        rf[v.rb] = v.vb;
        opcode   = v.op;
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start    = 1'b0;
        opcode   = 16'h0000;
        alu_R    = v.in_r;
        alu_S    = v.in_s;
        alu_resw = v.in_w;
        #1;
        chk($sformatf("v%0d exec busy", i), busy, 1);
        chk($sformatf("v%0d exec done", i), done, !v.two);
        chk($sformatf("v%0d exec err", i), err, v.er);
        chk($sformatf("v%0d mode", i), alu_mode, v.mode);
        chk($sformatf("v%0d alu_d", i), alu_d, v.ex_d);
        chk($sformatf("v%0d alu_r", i), alu_r, v.ex_r);
        chk($sformatf("v%0d alu_s", i), alu_s, exp_sreg);
        chk($sformatf("v%0d op1w", i), alu_op1w, v.ex_w);
        chk($sformatf("v%0d addr_a", i), rf_addr_a, v.ra);
        chk($sformatf("v%0d addr_b", i), rf_addr_b, v.rb);
        chk($sformatf("v%0d we", i), rf_we, v.we);
        chk($sformatf("v%0d waddr", i), rf_waddr, v.wa);
        chk($sformatf("v%0d wdata", i), rf_wdata, v.wd);
        if (v.upd)
            exp_sreg = v.in_s;
        @(posedge clock);
        @(negedge clock);
        if (v.two) begin
            alu_resw = 16'hDEAD;
            alu_R    = 8'hEE;
            #1;
            chk($sformatf("v%0d wrhi we", i), rf_we, 1);
            chk($sformatf("v%0d wrhi waddr", i), rf_waddr, v.ha);
            chk($sformatf("v%0d wrhi wdata", i), rf_wdata, v.hd);
            chk($sformatf("v%0d wrhi done", i), done, 1);
            chk($sformatf("v%0d wrhi sreg", i), sreg, exp_sreg);
            @(posedge clock);
            @(negedge clock);
        end
        alu_R    = 8'h00;
        alu_S    = 8'h00;
        alu_resw = 16'h0000;
        #1;
        chk($sformatf("v%0d idle busy", i), busy, 0);
        chk($sformatf("v%0d idle done", i), done, 0);
        chk($sformatf("v%0d sreg", i), sreg, exp_sreg);
        $display("vec %0d opcode=%04h sreg=%02h", i, v.op, sreg);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        start = 1'b0;
        opcode = 16'h0000;
        alu_R = 8'h00;
        alu_S = 8'h00;
        alu_resw = 16'h0000;
        for (int k = 0; k < 32; k++) rf[k] = 8'h00;

        //           op      ra     rb     va     vb     mode    ex_d   ex_r   ex_w      in_r   in_s   in_w      we    wa     wd     upd   two   er    ha     hd
        vecs[0]  = '{16'h0C12, 5'd1, 5'd2, 8'h7F, 8'h01, 5'd3,  8'h7F, 8'h01, 16'h0000, 8'h80, 8'h2C, 16'h1280, 1'b1, 5'd1,  8'h80, 1'b1, 1'b0, 1'b0, 5'd0,  8'h00}; // ADD r1,r2
        vecs[1]  = '{16'h1434, 5'd3, 5'd4, 8'h10, 8'h10, 5'd5,  8'h10, 8'h10, 16'h0000, 8'h00, 8'h02, 16'h0000, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 1'b0, 5'd0,  8'h00}; // CP r3,r4
        vecs[2]  = '{16'hEA45, 5'd20, 5'd0, 8'h33, 8'h00, 5'd0, 8'h33, 8'hA5, 16'h0000, 8'hA5, 8'hFF, 16'h0000, 1'b1, 5'd20, 8'hA5, 1'b0, 1'b0, 1'b0, 5'd0,  8'h00}; // LDI r20,0xA5
        vecs[3]  = '{16'h5011, 5'd17, 5'd0, 8'h10, 8'h00, 5'd6, 8'h10, 8'h01, 16'h0000, 8'h0F, 8'h20, 16'h0000, 1'b1, 5'd17, 8'h0F, 1'b1, 1'b0, 1'b0, 5'd0,  8'h00}; // SUBI r17,1
        vecs[4]  = '{16'h2455, 5'd5, 5'd5, 8'h5A, 8'h5A, 5'd9,  8'h5A, 8'h5A, 16'h0000, 8'h00, 8'h02, 16'h0000, 1'b1, 5'd5,  8'h00, 1'b1, 1'b0, 1'b0, 5'd0,  8'h00}; // EOR r5,r5
        vecs[5]  = '{16'h9462, 5'd6, 5'd0, 8'hC3, 8'h00, 5'd14, 8'hC3, 8'h00, 16'h0000, 8'h3C, 8'h99, 16'h0000, 1'b1, 5'd6,  8'h3C, 1'b0, 1'b0, 1'b0, 5'd0,  8'h00}; // SWAP r6
        vecs[6]  = '{16'h2C78, 5'd7, 5'd8, 8'h11, 8'h22, 5'd0,  8'h11, 8'h22, 16'h0000, 8'h22, 8'h77, 16'h0000, 1'b1, 5'd7,  8'h22, 1'b0, 1'b0, 1'b0, 5'd0,  8'h00}; // MOV r7,r8
        vecs[7]  = '{16'h95FA, 5'd31, 5'd0, 8'h01, 8'h00, 5'd19, 8'h01, 8'h00, 16'h0000, 8'h00, 8'h02, 16'h0000, 1'b1, 5'd31, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00}; // DEC r31
        vecs[8]  = '{16'h9601, 5'd24, 5'd25, 8'hFF, 8'hFF, 5'd20, 8'hFF, 8'h01, 16'hFFFF, 8'h5A, 8'h03, 16'h0000, 1'b1, 5'd24, 8'h00, 1'b1, 1'b1, 1'b0, 5'd25, 8'h00}; // ADIW r24,1
        vecs[9]  = '{16'h97EF, 5'd28, 5'd29, 8'h00, 8'h10, 5'd21, 8'h00, 8'h3F, 16'h1000, 8'hAA, 8'h14, 16'h0FC1, 1'b1, 5'd28, 8'hC1, 1'b1, 1'b1, 1'b0, 5'd29, 8'h0F}; // SBIW r28,0x3F
        vecs[10] = '{16'h9F01, 5'd16, 5'd17, 8'hFF, 8'hFF, 5'd23, 8'hFF, 8'hFF, 16'h0000, 8'h77, 8'h01, 16'hFE01, 1'b1, 5'd0,  8'h01, 1'b1, 1'b1, 1'b0, 5'd1,  8'hFE}; // MUL r16,r17
        vecs[11] = '{16'hFFFF, 5'd0, 5'd0, 8'h00, 8'h00, 5'd0,  8'h00, 8'h00, 16'h0000, 8'h12, 8'h34, 16'h5678, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 1'b1, 5'd0,  8'h00}; // illegal
        vecs[12] = '{16'h602F, 5'd18, 5'd0, 8'hF0, 8'h00, 5'd10, 8'hF0, 8'h0F, 16'h0000, 8'hFF, 8'h14, 16'h0000, 1'b1, 5'd18, 8'hFF, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00}; // ORI r18,0x0F

        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset we", rf_we, 0);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("post-reset sreg", sreg, 8'h00);
        chk("post-reset busy", busy, 0);
        chk("post-reset mode", alu_mode, 0);
        exp_sreg = 8'h00;

        for (int i = 0; i < NV; i++)
            run_vec(i);

        // start held during EXEC of ADIW must not disturb it or queue another op
        rf[24] = 8'hFF;
        rf[25] = 8'hFF;
        opcode = 16'h9601;
        start  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        opcode   = 16'h0C12;
        alu_resw = 16'h0000;
        alu_S    = 8'h03;
        #1;
        chk("busy-start exec waddr", rf_waddr, 5'd24);
        chk("busy-start exec mode", alu_mode, 5'd20);
        @(posedge clock);
        @(negedge clock);
        start    = 1'b0;
        alu_resw = 16'h1111;
        #1;
        chk("busy-start wrhi waddr", rf_waddr, 5'd25);
        chk("busy-start wrhi wdata", rf_wdata, 8'h00);
        chk("busy-start wrhi done", done, 1);
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("busy-start idle busy", busy, 0);
        chk("busy-start sreg", sreg, 8'h03);
        $display("seq start-while-busy sreg=%02h", sreg);

        // reset in WRHI drops the high-byte write and clears sreg
        opcode = 16'h9601;
        start  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start    = 1'b0;
        alu_resw = 16'h0000;
        alu_S    = 8'h07;
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("rst-wrhi sreg before", sreg, 8'h07);
        reset = 1'b1;
        #1;
        chk("rst-wrhi we", rf_we, 0);
        chk("rst-wrhi done", done, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst-wrhi busy", busy, 0);
        chk("rst-wrhi sreg", sreg, 8'h00);
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("rst-wrhi stays idle", busy, 0);
        $display("seq reset-in-wrhi sreg=%02h", sreg);

        // reset in EXEC drops the low write and the flag update
        rf[1]  = 8'h7F;
        rf[2]  = 8'h01;
        opcode = 16'h0C12;
        start  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        alu_R = 8'h80;
        alu_S = 8'hFF;
        reset = 1'b1;
        #1;
        chk("rst-exec we", rf_we, 0);
        chk("rst-exec done", done, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        alu_S = 8'h00;
        #1;
        chk("rst-exec sreg", sreg, 8'h00);
        chk("rst-exec busy", busy, 0);
        $display("seq reset-in-exec sreg=%02h", sreg);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
